// File: rtl/arm_bus_pkg.sv
// Shared types and constants for the ARM926 CS5 bus sequencer.
// Holds the FSM state encoding, error bit positions and defaults.
package arm_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT,
        ACK,
        RELEASE
    } state_t;

    localparam int ERR_W           = 2;
    localparam int ERR_TIMEOUT     = 0;
    localparam int ERR_BOTH        = 1;
    localparam int BE_W            = 4;
    localparam int CNT_W           = 8;
    localparam int ACK_TIMEOUT_DEF = 255;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer for asynchronous ARM strobes.
// Reset value is a parameter so each strobe resets to its inactive level.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/arm_bus_ctrl.sv
// ARM926 CS5 strobe sequencer: synchronizes strobes and issues exactly
// one register-file access per ARM cycle, then holds DTACK until release.
module arm_bus_ctrl
    import arm_bus_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_as,
    input  logic              i_ws_n,
    input  logic              i_rs_n,
    input  logic [BE_W-1:0]   i_be_n,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic [DATA_W-1:0] i_rf_rdata,
    input  logic              i_err_clr,
    output logic [ADDR_W-1:0] o_rf_addr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic [BE_W-1:0]   o_rf_be,
    output logic              o_rf_we,
    output logic              o_rf_re,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_data_oe,
    output logic              o_dtack_n,
    output logic              o_busy,
    output logic [ERR_W-1:0]  o_err
);

    // Last ACK cycle index before the access is aborted
    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic w_as_s;
    logic w_ws_s;
    logic w_rs_s;
    logic w_start_wr;
    logic w_start_rd;
    logic w_start_both;
    logic w_strb_rel;
    logic w_rel;

    state_t            r_state;
    logic              r_is_rd;
    logic              r_both;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [BE_W-1:0]   r_rf_be;
    logic              r_rf_we;
    logic              r_rf_re;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_oe;
    logic              r_dtack_n;
    logic              r_busy;
    logic [ERR_W-1:0]  r_err;

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_as (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_as),
        .o_q   (w_as_s)
    );

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_ws (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_ws_n),
        .o_q   (w_ws_s)
    );

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_rs (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_rs_n),
        .o_q   (w_rs_s)
    );

    assign w_start_wr   = w_as_s & ~w_ws_s &  w_rs_s;
    assign w_start_rd   = w_as_s &  w_ws_s & ~w_rs_s;
    assign w_start_both = w_as_s & ~w_ws_s & ~w_rs_s;

    // Strobe release: address strobe gone or the strobe that started us is high
    always_comb begin
        w_strb_rel = w_ws_s;
        if (r_both) begin
            w_strb_rel = w_ws_s & w_rs_s;
        end else if (r_is_rd) begin
            w_strb_rel = w_rs_s;
        end
        w_rel = ~w_as_s | w_strb_rel;
    end

    // Access sequencer with registered bus and register-file outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_is_rd    <= 1'b0;
            r_both     <= 1'b0;
            r_cnt      <= '0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_rf_be    <= '0;
            r_rf_we    <= 1'b0;
            r_rf_re    <= 1'b0;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
            r_dtack_n  <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= '0;
        end else begin
            r_rf_we <= 1'b0;
            r_rf_re <= 1'b0;
            if (i_err_clr) begin
                r_err <= '0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_start_wr) begin
                        r_rf_addr  <= i_address;
                        r_rf_wdata <= i_data_in;
                        r_rf_be    <= ~i_be_n;
                        r_is_rd    <= 1'b0;
                        r_both     <= 1'b0;
                        r_rf_we    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= WRITE;
                    end else if (w_start_rd) begin
                        r_rf_addr  <= i_address;
                        r_rf_wdata <= i_data_in;
                        r_rf_be    <= ~i_be_n;
                        r_is_rd    <= 1'b1;
                        r_both     <= 1'b0;
                        r_rf_re    <= 1'b1;
                        r_data_oe  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= READ;
                    end else if (w_start_both) begin
                        r_is_rd         <= 1'b0;
                        r_both          <= 1'b1;
                        r_err[ERR_BOTH] <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= RELEASE;
                    end
                end
                WRITE: begin
                    r_dtack_n <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= ACK;
                end
                READ: begin
                    r_state <= RDWAIT;
                end
                RDWAIT: begin
                    r_data_out <= i_rf_rdata;
                    r_dtack_n  <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= ACK;
                end
                ACK: begin
                    if (w_rel) begin
                        r_dtack_n <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_cnt >= LP_TO_LAST) begin
                        r_err[ERR_TIMEOUT] <= 1'b1;
                        r_dtack_n          <= 1'b1;
                        r_state            <= RELEASE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (w_rel) begin
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_dtack_n <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_rf_addr  = r_rf_addr;
    assign o_rf_wdata = r_rf_wdata;
    assign o_rf_be    = r_rf_be;
    assign o_rf_we    = r_rf_we;
    assign o_rf_re    = r_rf_re;
    assign o_data_out = r_data_out;
    assign o_data_oe  = r_data_oe;
    assign o_dtack_n  = r_dtack_n;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule

// File: tb/tb_arm_bus_ctrl.sv
// Self-checking bench for arm_bus_ctrl: random ARM reads and writes
// checked cycle by cycle against latencies derived from the bus rules.
module tb_arm_bus_ctrl;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SS = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          as_i = 1'b0;
    logic          ws_n = 1'b1;
    logic          rs_n = 1'b1;
    logic [3:0]    be_n = 4'hF;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] rf_rdata = '0;
    logic          err_clr = 1'b0;
    logic [AW-1:0] o_rf_addr;
    logic [DW-1:0] o_rf_wdata;
    logic [3:0]    o_rf_be;
    logic          o_rf_we;
    logic          o_rf_re;
    logic [DW-1:0] o_data_out;
    logic          o_data_oe;
    logic          o_dtack_n;
    logic          o_busy;
    logic [1:0]    o_err;

    int n_pass = 0;
    int n_tot  = 0;
    int n_we   = 0;
    int n_re   = 0;

    arm_bus_ctrl #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_as       (as_i),
        .i_ws_n     (ws_n),
        .i_rs_n     (rs_n),
        .i_be_n     (be_n),
        .i_address  (address),
        .i_data_in  (data_in),
        .i_rf_rdata (rf_rdata),
        .i_err_clr  (err_clr),
        .o_rf_addr  (o_rf_addr),
        .o_rf_wdata (o_rf_wdata),
        .o_rf_be    (o_rf_be),
        .o_rf_we    (o_rf_we),
        .o_rf_re    (o_rf_re),
        .o_data_out (o_data_out),
        .o_data_oe  (o_data_oe),
        .o_dtack_n  (o_dtack_n),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // Count register-file strobes seen on the bus
    always @(negedge clk) begin
        if (o_rf_we) n_we++;
        if (o_rf_re) n_re++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        as_i = 1'b0;
        ws_n = 1'b1;
        rs_n = 1'b1;
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int k;
        k = 0;
        while (o_busy !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        n_tot++;
        if (o_busy !== 1'b0) $display("FAIL %s_idle busy=%b exp 0", nm, o_busy);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_bus();
        tick();
        tick();
        n_tot++;
        if ({o_rf_we, o_rf_re, o_data_oe, o_dtack_n, o_busy} !== 5'b00010)
            $display("FAIL rst_ctl got %b exp 00010",
                     {o_rf_we, o_rf_re, o_data_oe, o_dtack_n, o_busy});
        else n_pass++;
        n_tot++;
        if (o_err !== 2'b00) $display("FAIL rst_err got %b exp 00", o_err);
        else n_pass++;
        n_tot++;
        if ({o_rf_addr, o_rf_wdata, o_rf_be, o_data_out} !== '0)
            $display("FAIL rst_data got %h %h %h %h exp 0",
                     o_rf_addr, o_rf_wdata, o_rf_be, o_data_out);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        tick();
        n_tot++;
        if ({o_busy, o_dtack_n} !== 2'b01)
            $display("FAIL rst_rel got %b exp 01", {o_busy, o_dtack_n});
        else n_pass++;
    endtask

    task automatic test_write(int n);
        for (int t = 0; t < n; t++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [3:0]    b;
            int h;
            int mode;
            int we0;
            a = AW'($urandom);
            d = $urandom;
            b = 4'($urandom);
            h = $urandom_range(8, 4);
            mode = $urandom_range(2, 0);
            if (t == 0) begin
                a = 24'h000004;
                d = 32'hDEADBEEF;
                b = 4'b0000;
            end
            we0 = n_we;
            address = a;
            data_in = d;
            be_n = b;
            as_i = 1'b1;
            ws_n = 1'b0;
            for (int c = 1; c <= h; c++) begin
                tick();
                n_tot++;
                if (o_rf_we !== (c == 3))
                    $display("FAIL wr_we c=%0d got %b exp %b", c, o_rf_we, c == 3);
                else n_pass++;
                n_tot++;
                if (o_dtack_n !== (c < 4))
                    $display("FAIL wr_dtack c=%0d got %b exp %b", c, o_dtack_n, c < 4);
                else n_pass++;
                if (c == 3) begin
                    n_tot++;
                    if ({o_rf_addr, o_rf_wdata, o_rf_be} !== {a, d, ~b})
                        $display("FAIL wr_cap got %h %h %h exp %h %h %h",
                                 o_rf_addr, o_rf_wdata, o_rf_be, a, d, ~b);
                    else n_pass++;
                end
                if (c == 4) begin
                    address = ~a;
                    data_in = ~d;
                    be_n = ~b;
                end
            end
            if (mode != 2) as_i = 1'b0;
            if (mode != 1) ws_n = 1'b1;
            for (int r = 1; r <= 3; r++) begin
                tick();
                n_tot++;
                if (o_dtack_n !== (r == 3))
                    $display("FAIL wr_rel r=%0d got %b exp %b", r, o_dtack_n, r == 3);
                else n_pass++;
            end
            n_tot++;
            if (n_we - we0 !== 1 || o_busy !== 1'b0)
                $display("FAIL wr_count got %0d busy %b exp 1 busy 0", n_we - we0, o_busy);
            else n_pass++;
            idle_bus();
            tick();
            tick();
        end
    endtask

    task automatic test_read(int n);
        for (int t = 0; t < n; t++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] rd;
            int h;
            int re0;
            a = AW'($urandom);
            rd = $urandom;
            h = $urandom_range(9, 5);
            if (t == 0) rd = 32'h12345678;
            re0 = n_re;
            rf_rdata = ~rd;
            address = a;
            as_i = 1'b1;
            rs_n = 1'b0;
            for (int c = 1; c <= h; c++) begin
                tick();
                n_tot++;
                if (o_rf_re !== (c == 3))
                    $display("FAIL rd_re c=%0d got %b exp %b", c, o_rf_re, c == 3);
                else n_pass++;
                n_tot++;
                if ({o_dtack_n, o_data_oe} !== {c < 5, c >= 3})
                    $display("FAIL rd_ctl c=%0d got %b%b exp %b%b",
                             c, o_dtack_n, o_data_oe, c < 5, c >= 3);
                else n_pass++;
                if (c >= 5) begin
                    n_tot++;
                    if (o_data_out !== rd)
                        $display("FAIL rd_data c=%0d got %h exp %h", c, o_data_out, rd);
                    else n_pass++;
                end
                if (c == 3) begin
                    n_tot++;
                    if (o_rf_addr !== a)
                        $display("FAIL rd_addr got %h exp %h", o_rf_addr, a);
                    else n_pass++;
                    rf_rdata = rd;
                end
                if (c == 5) rf_rdata = $urandom;
            end
            rs_n = 1'b1;
            if ($urandom_range(1, 0) == 1) as_i = 1'b0;
            for (int r = 1; r <= 3; r++) begin
                tick();
                n_tot++;
                if ({o_dtack_n, o_data_oe} !== {r == 3, r < 3})
                    $display("FAIL rd_rel r=%0d got %b%b exp %b%b",
                             r, o_dtack_n, o_data_oe, r == 3, r < 3);
                else n_pass++;
            end
            n_tot++;
            if (n_re - re0 !== 1 || o_data_out !== rd)
                $display("FAIL rd_count got %0d %h exp 1 %h", n_re - re0, o_data_out, rd);
            else n_pass++;
            idle_bus();
            tick();
            tick();
        end
    endtask

    task automatic test_long_write();
        int we0;
        we0 = n_we;
        address = AW'($urandom);
        data_in = $urandom;
        be_n = 4'b1100;
        as_i = 1'b1;
        ws_n = 1'b0;
        for (int c = 1; c <= 50; c++) tick();
        n_tot++;
        if (n_we - we0 !== 1) $display("FAIL long_we got %0d exp 1", n_we - we0);
        else n_pass++;
        n_tot++;
        if (o_rf_be !== 4'b0011) $display("FAIL long_be got %b exp 0011", o_rf_be);
        else n_pass++;
        n_tot++;
        if ({o_err, o_dtack_n, o_busy} !== 4'b0111)
            $display("FAIL long_to got %b exp 0111", {o_err, o_dtack_n, o_busy});
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tot++;
        if (o_err !== 2'b00) $display("FAIL long_clr got %b exp 00", o_err);
        else n_pass++;
        idle_bus();
        wait_idle("long");
    endtask

    task automatic test_timeout();
        int re0;
        re0 = n_re;
        rf_rdata = $urandom;
        as_i = 1'b1;
        rs_n = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_tot++;
            if ({o_dtack_n, o_data_oe} !== {!(c >= 5 && c <= 12), c >= 3})
                $display("FAIL to_ctl c=%0d got %b%b exp %b%b", c, o_dtack_n,
                         o_data_oe, !(c >= 5 && c <= 12), c >= 3);
            else n_pass++;
            if (c == 12 || c == 13) begin
                n_tot++;
                if (o_err !== ((c == 13) ? 2'b01 : 2'b00))
                    $display("FAIL to_err c=%0d got %b", c, o_err);
                else n_pass++;
            end
        end
        n_tot++;
        if (n_re - re0 !== 1) $display("FAIL to_re got %0d exp 1", n_re - re0);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tot++;
        if (o_err !== 2'b00) $display("FAIL to_clr got %b exp 00", o_err);
        else n_pass++;
        rs_n = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            tick();
            n_tot++;
            if ({o_data_oe, o_busy} !== {r < 3, r < 3})
                $display("FAIL to_rel r=%0d got %b%b", r, o_data_oe, o_busy);
            else n_pass++;
        end
        idle_bus();
        tick();
        tick();
    endtask

    task automatic test_both();
        int we0;
        int re0;
        we0 = n_we;
        re0 = n_re;
        as_i = 1'b1;
        ws_n = 1'b0;
        rs_n = 1'b0;
        err_clr = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_tot++;
            if (o_dtack_n !== 1'b1) $display("FAIL both_dtack c=%0d got %b exp 1", c, o_dtack_n);
            else n_pass++;
            if (c == 3) begin
                n_tot++;
                if ({o_err, o_busy} !== 3'b101)
                    $display("FAIL both_err got %b exp 101", {o_err, o_busy});
                else n_pass++;
            end
            if (c == 4) begin
                n_tot++;
                if (o_err !== 2'b00) $display("FAIL both_clr got %b exp 00", o_err);
                else n_pass++;
                err_clr = 1'b0;
            end
        end
        n_tot++;
        if (n_we - we0 !== 0 || n_re - re0 !== 0)
            $display("FAIL both_acc got we %0d re %0d exp 0 0", n_we - we0, n_re - re0);
        else n_pass++;
        idle_bus();
        wait_idle("both");
    endtask

    task automatic test_reset_mid();
        int re0;
        int first;
        rf_rdata = $urandom;
        as_i = 1'b1;
        rs_n = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        n_tot++;
        if (o_dtack_n !== 1'b0) $display("FAIL rm_ack got %b exp 0", o_dtack_n);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_tot++;
        if ({o_dtack_n, o_data_oe, o_busy, o_rf_re} !== 4'b1000 || o_data_out !== '0)
            $display("FAIL rm_rst got %b %h exp 1000 0",
                     {o_dtack_n, o_data_oe, o_busy, o_rf_re}, o_data_out);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        re0 = n_re;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (o_rf_re === 1'b1 && first == 0) first = k;
        end
        n_tot++;
        if (first != 3 || n_re - re0 !== 1)
            $display("FAIL rm_new got k=%0d n=%0d exp k=3 n=1", first, n_re - re0);
        else n_pass++;
        idle_bus();
        wait_idle("rm");
    endtask

    initial begin
        test_reset();
        test_write(5);
        test_read(5);
        test_write(2);
        test_long_write();
        test_timeout();
        test_both();
        test_read(2);
        test_reset_mid();
        test_write(1);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
